div_unit: RTL and testbench
===========================

# div_unit

Iterative multi-cycle divider that executes the RV32M DIV, DIVU, REM and REMU instructions alongside the single-cycle ALU in the execute stage. It accepts operands through a start/busy/done handshake and computes one quotient bit per cycle using restoring division on operand magnitudes. It returns a registered result with the same zero/negative flag semantics as the ALU, so the downstream flag and writeback logic is shared. The pipeline stalls on `busy`.

## Interface
- `n`, 32, operand and result width (≥ 4)
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request; sampled only in IDLE or DONE
- `kill`  in  1  abort in-flight operation (pipeline flush)
- `div_ctrl`  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- `rs1`  in  n  dividend; captured on accepted start
- `rs2`  in  n  divisor; captured on accepted start
- `busy`  out  1  high while an operation is in flight (CALC or FIX)
- `done`  out  1  one-cycle pulse; `res`/`zf`/`neg` valid
- `res`  out  n  quotient or remainder; held until the next `done`
- `zf`  out  1  `res == 0`, registered with `res`
- `neg`  out  1  `res[n-1]`, registered with `res`

## Operation
- States: IDLE, CALC, FIX, DONE.
- Accept happens when `start`=1 and state is IDLE or DONE, with `kill`=0. On accept:
  - latch op, operand signs and magnitudes;
  - signed ops (DIV/REM) take the two's-complement magnitude of negative operands;
  - unsigned ops use the raw operands.
- Fast path: divisor == 0 or signed overflow (`rs1`=0x80000000, `rs2`=0xFFFFFFFF, DIV/REM) goes IDLE/DONE → FIX, skipping CALC.
- CALC runs exactly n iterations, driven by a log2(n)+1-bit counter:
  - shift {rem, dividend} left by one;
  - trial subtract divisor from rem;
  - if the result is non-negative, keep it and set the quotient LSB to 1.
- FIX selects and sign-corrects the result:
  - quotient is negated if the operand signs differ (DIV);
  - remainder takes the sign of the dividend (REM);
  - divide by zero: quotient = all ones, remainder = `rs1`;
  - overflow: quotient = 0x80000000, remainder = 0.
- FIX registers `res`, `zf`, `neg` and sets `done`, then moves to DONE.
- DONE lasts one cycle, then returns to IDLE unless a new start is accepted in it.
- `start` in CALC or FIX is ignored; there is no queueing.
- `kill` in CALC or FIX → IDLE on the next edge. In that case `done` is not asserted and `res`/`zf`/`neg` keep their previous values. `kill` has priority over `start`.
- All arithmetic is n+1 bits wide internally, so the trial subtract never loses its borrow.

## Timing
- Reset (async, any state): state = IDLE, `busy`=0, `done`=0, `res`=0, `zf`=1, `neg`=0, counter = 0.
- Accept is on edge E0. `busy`=1 from E0.
- Normal path:
  - CALC occupies edges E1..En;
  - FIX updates outputs at edge E(n+1);
  - `done`=1 and `busy`=0 during the cycle after E(n+1), which is n+1 cycles after accept (33 for n=32).
- Fast path: FIX at E1, so `done` is high in the cycle after E1.
- `done` is exactly one cycle wide.
- Back-to-back: a `start` sampled while `done`=1 is accepted. Throughput is one op per n+2 cycles.
- Reset deassertion mid-operation: resumes in IDLE. A pending `start` is not accepted until the first edge with `rst_n`=1.

## Test plan
- DIVU 100 / 7 → `done` at cycle 33 after accept, `res`=14, `zf`=0, `neg`=0. Repeat as REMU → `res`=2.
- DIV −7 / 2 → `res`=0xFFFFFFFD, `neg`=1. REM −7 / 2 → `res`=0xFFFFFFFF.
- DIV 5 / 0 → fast path, `done` 1 cycle after accept, `res`=0xFFFFFFFF. REM 5 / 0 → `res`=5. DIVU 0 / 0 → `res`=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → `res`=0x80000000, `neg`=1. REM on the same operands → `res`=0, `zf`=1.
- Start DIVU 100/7 and assert `kill` at cycle 10 → IDLE next cycle, no `done`, `res` unchanged. Issue `start` while `busy` → ignored. Assert `rst_n`=0 mid-CALC → immediately `busy`=0, `res`=0, `zf`=1.
- Back-to-back: assert `start` in the `done` cycle with DIVU 9/3 → first result is correct, second `done` arrives 33 cycles later with `res`=3.

Source files
------------

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit : iterative restoring divider for RV32M DIV / DIVU / REM / REMU.
//
// One quotient bit is produced per clock on operand magnitudes; a final FIX
// cycle applies the sign rules and the divide-by-zero / signed-overflow
// results. The registered result carries the same zero/negative flags as the
// ALU so the downstream flag and writeback logic can be shared.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   request; honoured only in IDLE or DONE with kill low
//   kill      in   abort in-flight operation (pipeline flush), beats start
//   div_ctrl  in   00 DIV, 01 DIVU, 10 REM, 11 REMU
//   rs1       in   dividend, captured on accept
//   rs2       in   divisor, captured on accept
//   busy      out  operation in flight (CALC or FIX); pipeline stalls on it
//   done      out  one-cycle pulse, res/zf/neg valid
//   res       out  quotient or remainder, held until the next done
//   zf        out  res == 0
//   neg       out  res[DATA_W-1]
// -----------------------------------------------------------------------------
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              kill,
  input  logic [1:0]        div_ctrl,
  input  logic [DATA_W-1:0] rs1,
  input  logic [DATA_W-1:0] rs2,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] res,
  output logic              zf,
  output logic              neg
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  // Two's-complement negation.
  function automatic logic [DATA_W-1:0] neg2c(input logic [DATA_W-1:0] v);
    return ~v + 1'b1;
  endfunction

  // Negate v when en is set; used both for magnitudes and for sign fix-up.
  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v,
                                                 input logic              en);
    return en ? neg2c(v) : v;
  endfunction

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;

  // Operation context captured on accept.
  logic               op_rem;
  logic               sign_a;
  logic               sign_b;
  logic               dz_q;
  logic               ovf_q;
  logic [DATA_W-1:0]  a_raw;

  // Iteration state: partial remainder, dividend shifting out / quotient
  // shifting in (same register), divisor magnitude.
  logic [DATA_W-1:0]  rem_q;
  logic [DATA_W-1:0]  quo_q;
  logic [DATA_W-1:0]  dvs_q;

  logic               accept;
  logic               is_signed;
  logic               rs1_neg;
  logic               rs2_neg;
  logic               div_zero;
  logic               ovf;
  logic               last_iter;

  logic [DATA_W:0]        shifted;
  logic signed [DATA_W:0] trial;
  logic                   trial_ok;
  logic [DATA_W-1:0]      fix_res;

  assign accept    = start && !kill && ((state == IDLE) || (state == DONE));
  assign is_signed = !div_ctrl[0];
  assign rs1_neg   = is_signed && rs1[DATA_W-1];
  assign rs2_neg   = is_signed && rs2[DATA_W-1];
  assign div_zero  = (rs2 == '0);
  assign ovf       = is_signed && (rs1 == MIN_VAL) && (rs2 == '1);
  assign last_iter = (cnt == CNT_W'(DATA_W - 1));

  // The shifted remainder is below twice the divisor, so an (n+1)-bit
  // subtract keeps the borrow in the top bit.
  assign shifted  = {rem_q, quo_q[DATA_W-1]};
  assign trial    = $signed(shifted - {1'b0, dvs_q});
  assign trial_ok = (trial >= 0);

  always_comb begin
    fix_res = '0;
    if (dz_q) begin
      fix_res = op_rem ? a_raw : '1;
    end else if (ovf_q) begin
      fix_res = op_rem ? '0 : MIN_VAL;
    end else if (op_rem) begin
      fix_res = cond_neg(rem_q, sign_a);
    end else begin
      fix_res = cond_neg(quo_q, sign_a ^ sign_b);
    end
  end

  // ---- control: state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- control: next state ----
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          state_nxt = (div_zero || ovf) ? FIX : CALC;
        end else begin
          state_nxt = IDLE;
        end
      end
      CALC: begin
        if (kill) begin
          state_nxt = IDLE;
        end else if (last_iter) begin
          state_nxt = FIX;
        end
      end
      FIX: begin
        state_nxt = kill ? IDLE : DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- control: outputs ----
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      CALC, FIX: busy = 1'b1;
      DONE:      done = 1'b1;
      default: ;
    endcase
  end

  // ---- iteration counter ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (state == CALC) begin
      cnt <= cnt + 1'b1;
    end
  end

  // ---- operand capture and restoring iteration ----
  always_ff @(posedge clk) begin
    if (accept) begin
      op_rem <= div_ctrl[1];
      sign_a <= rs1_neg;
      sign_b <= rs2_neg;
      dz_q   <= div_zero;
      ovf_q  <= ovf;
      a_raw  <= rs1;
      rem_q  <= '0;
      quo_q  <= cond_neg(rs1, rs1_neg);
      dvs_q  <= cond_neg(rs2, rs2_neg);
    end else if (state == CALC) begin
      rem_q <= trial_ok ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
      quo_q <= {quo_q[DATA_W-2:0], trial_ok};
    end
  end

  // ---- result register, written only by a FIX that is not killed ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res <= '0;
      zf  <= 1'b1;
      neg <= 1'b0;
    end else if ((state == FIX) && !kill) begin
      res <= fix_res;
      zf  <= (fix_res == '0);
      neg <= fix_res[DATA_W-1];
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit : scoreboard bench for div_unit.
// Stimulus pushes hand-computed results (value, flags, done cycle) into a
// queue; an independent monitor on the falling edge pops and compares each
// time done is seen. Direct state checks (reset, kill) are handed to the
// monitor through a probe sequence number so only the monitor owns counters.
// -----------------------------------------------------------------------------
module tb_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         kill = 1'b0;
  logic [1:0]   div_ctrl = 2'b00;
  logic [W-1:0] rs1 = '0;
  logic [W-1:0] rs2 = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] res;
  logic         zf;
  logic         neg;

  div_unit #(.DATA_W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .kill     (kill),
    .div_ctrl (div_ctrl),
    .rs1      (rs1),
    .rs2      (rs2),
    .busy     (busy),
    .done     (done),
    .res      (res),
    .zf       (zf),
    .neg      (neg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         zf;
    logic         neg;
    int           cyc;
    int           id;
  } exp_t;

  exp_t sb[$];

  // Written by stimulus only.
  int           probe_seq = 0;
  int           probe_id = 0;
  logic         p_busy, p_done, p_zf, p_neg;
  logic [W-1:0] p_res;
  int           timeouts = 0;

  // Written by monitor only.
  int   errors = 0;
  int   checks = 0;
  int   seen_probe = 0;
  int   seen_to = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string nm, input int id, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h, required %h", nm, id, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      checks++;
      if (prev_done) begin
        errors++;
        $display("FAIL done_width: done high two cycles in a row, required one");
      end
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with res=%h, required no done", res);
      end else begin
        e = sb.pop_front();
        chk("res",   e.id, res,        e.res);
        chk("zf",    e.id, W'(zf),     W'(e.zf));
        chk("neg",   e.id, W'(neg),    W'(e.neg));
        chk("cycle", e.id, W'(cyc),    W'(e.cyc));
      end
    end
    prev_done = done;
    if (probe_seq != seen_probe) begin
      seen_probe = probe_seq;
      chk("probe_busy", probe_id, W'(busy), W'(p_busy));
      chk("probe_done", probe_id, W'(done), W'(p_done));
      chk("probe_res",  probe_id, res,      p_res);
      chk("probe_zf",   probe_id, W'(zf),   W'(p_zf));
      chk("probe_neg",  probe_id, W'(neg),  W'(p_neg));
    end
    if (timeouts != seen_to) begin
      seen_to = timeouts;
      checks++;
      errors++;
      $display("FAIL timeout: got no done within budget, required done");
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called between clock edges; the next rising edge is the accept edge.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] r,
                       input int lat, input bit push, input int id);
    exp_t e;
    div_ctrl = op;
    rs1      = a;
    rs2      = b;
    start    = 1'b1;
    if (push) begin
      e.res = r;
      e.zf  = (r == '0);
      e.neg = r[W-1];
      e.cyc = cyc + 1 + lat;
      e.id  = id;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) timeouts++;
    repeat (2) @(negedge clk);
  endtask

  // Set up a direct-state expectation; the monitor compares at the next
  // falling edge.
  task automatic probe(input logic b, input logic d, input logic [W-1:0] r,
                       input logic z, input logic n, input int id);
    p_busy   = b;
    p_done   = d;
    p_res    = r;
    p_zf     = z;
    p_neg    = n;
    probe_id = id;
    probe_seq++;
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    int           lat;
  } vec_t;

  // op: 00 DIV, 01 DIVU, 10 REM, 11 REMU. lat 33 = normal path, 1 = fast path.
  vec_t vt [21] = '{
    '{2'b01, 32'd100,      32'd7,        32'd14,       33},
    '{2'b11, 32'd100,      32'd7,        32'd2,        33},
    '{2'b00, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33},
    '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33},
    '{2'b00, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33},
    '{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        33},
    '{2'b00, 32'hFFFFFFF8, 32'hFFFFFFFE, 32'd4,        33},
    '{2'b10, 32'hFFFFFFF7, 32'hFFFFFFFC, 32'hFFFFFFFF, 33},
    '{2'b01, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33},
    '{2'b11, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 33},
    '{2'b01, 32'd0,        32'd5,        32'd0,        33},
    '{2'b00, 32'h80000000, 32'd2,        32'hC0000000, 33},
    '{2'b00, 32'd5,        32'd0,        32'hFFFFFFFF, 1},
    '{2'b10, 32'd5,        32'd0,        32'd5,        1},
    '{2'b10, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1},
    '{2'b01, 32'd0,        32'd0,        32'hFFFFFFFF, 1},
    '{2'b11, 32'd7,        32'd0,        32'd7,        1},
    '{2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1},
    '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1},
    '{2'b01, 32'h80000000, 32'hFFFFFFFF, 32'd0,        33},
    '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33}
  };

  // ---------------- stimulus ----------------
  initial begin
    exp_t e;
    int   n;

    // Reset state, while asserted and right after release.
    repeat (3) @(posedge clk);
    #1;
    probe(1'b0, 1'b0, '0, 1'b1, 1'b0, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    probe(1'b0, 1'b0, '0, 1'b1, 1'b0, 2);

    // Directed vectors.
    foreach (vt[i]) begin
      @(negedge clk);
      issue(vt[i].op, vt[i].a, vt[i].b, vt[i].r, vt[i].lat, 1'b1, 100 + i);
      drain(60);
    end

    // Busy from the accept edge; kill mid-CALC leaves the last result.
    @(negedge clk);
    issue(2'b01, 32'd100, 32'd7, '0, 0, 1'b0, 0);
    probe(1'b1, 1'b0, 32'h80000000, 1'b0, 1'b1, 3);
    repeat (8) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    probe(1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 4);
    repeat (45) @(negedge clk);

    // A start while busy must not restart or queue.
    @(negedge clk);
    issue(2'b01, 32'd100, 32'd7, 32'd14, 33, 1'b1, 200);
    repeat (4) @(negedge clk);
    div_ctrl = 2'b01;
    rs1      = 32'd9;
    rs2      = 32'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain(60);
    repeat (5) @(negedge clk);

    // Back-to-back: second start presented in the done cycle.
    @(negedge clk);
    issue(2'b01, 32'd100, 32'd7, 32'd14, 33, 1'b1, 201);
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!done) timeouts++;
    issue(2'b01, 32'd9, 32'd3, 32'd3, 33, 1'b1, 202);
    drain(60);

    // Reset mid-CALC clears outputs at once; a start held through reset is
    // taken on the first edge with rst_n high.
    @(negedge clk);
    issue(2'b01, 32'd100, 32'd7, '0, 0, 1'b0, 0);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    probe(1'b0, 1'b0, '0, 1'b1, 1'b0, 5);
    div_ctrl = 2'b01;
    rs1      = 32'd9;
    rs2      = 32'd3;
    start    = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    e.res = 32'd3;
    e.zf  = 1'b0;
    e.neg = 1'b0;
    e.cyc = cyc + 1 + 33;
    e.id  = 203;
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    drain(60);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, required finish before time limit");
    $fatal(1);
  end

endmodule
